// File: rtl/sdiv_16bit_pkg.sv
// Shared constants and state encoding for the signed 16-bit sequential divider.
package sdiv_16bit_pkg;

  localparam int SDIV_W = 16;

  localparam logic [SDIV_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [SDIV_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIN  = 2'd3
  } sdiv_state_t;

endpackage

// File: rtl/addsub_17bit.sv
// 17-bit combinational adder/subtractor; sub inverts b and feeds the carry-in.
module addsub_17bit (
  input  logic [16:0] a,
  input  logic [16:0] b,
  input  logic        sub,
  output logic [16:0] s,
  output logic        cout
);

  logic [17:0] sum;

  // With sub=1, cout=1 means a >= b (no borrow).
  assign sum  = {1'b0, a} + {1'b0, b ^ {17{sub}}} + {17'd0, sub};
  assign s    = sum[16:0];
  assign cout = sum[17];

endmodule

// File: rtl/sdiv_16bit.sv
// Signed 16-bit restoring divider, one quotient bit per cycle, fixed 18-edge latency.
//
// state | meaning
// IDLE  | waiting for start; done may be high here for one cycle
// PREP  | take magnitudes and signs of the captured operands, clear counter
// ITER  | one shift/subtract step per cycle, 16 cycles
// FIN   | apply signs / divide-by-zero / overflow rules, register results
module sdiv_16bit
  import sdiv_16bit_pkg::*;
#(
  parameter int W = SDIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         dvz,
  output logic         ovfl
);

  sdiv_state_t  state;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic         sa;
  logic         sb;
  logic [W-1:0] qd;
  logic [W-1:0] bmag;
  logic [W:0]   rem;
  logic [3:0]   cnt;

  logic [W:0]   rem_sh;
  logic [W:0]   diff;
  logic         no_borrow;

  // Dividend magnitude shifts out of qd's top while quotient bits shift in below.
  assign rem_sh = {rem[W-1:0], qd[W-1]};

  addsub_17bit u_step (
    .a    (rem_sh),
    .b    ({1'b0, bmag}),
    .sub  (1'b1),
    .s    (diff),
    .cout (no_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      qd    <= '0;
      bmag  <= '0;
      rem   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Q     <= '0;
      R     <= '0;
      dvz   <= 1'b0;
      ovfl  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          // Unary minus of 0x8000 yields 0x8000, read as unsigned magnitude.
          sa    <= a_reg[W-1];
          sb    <= b_reg[W-1];
          qd    <= a_reg[W-1] ? -a_reg : a_reg;
          bmag  <= b_reg[W-1] ? -b_reg : b_reg;
          rem   <= '0;
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          rem   <= no_borrow ? diff : rem_sh;
          qd    <= {qd[W-2:0], no_borrow};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15)
            state <= FIN;
        end
        FIN: begin
          if (b_reg == '0) begin
            Q    <= sa ? SAT_NEG : SAT_POS;
            R    <= a_reg;
            dvz  <= 1'b1;
            ovfl <= 1'b0;
          end else if (a_reg == SAT_NEG && b_reg == '1) begin
            Q    <= SAT_POS;
            R    <= '0;
            dvz  <= 1'b0;
            ovfl <= 1'b1;
          end else begin
            Q    <= (sa ^ sb) ? -qd : qd;
            R    <= sa ? -rem[W-1:0] : rem[W-1:0];
            dvz  <= 1'b0;
            ovfl <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdiv_16bit.sv
// Scoreboard bench for sdiv_16bit: directed corner cases plus randomized divides.
module tb_sdiv_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, done, dvz, ovfl;
  logic [15:0] Q, R;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dvz;
    logic        ovfl;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sdiv_16bit #(.W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .dvz   (dvz),
    .ovfl  (ovfl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic with the saturation rules.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int acc);
    exp_t e;
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    e.acc = acc;
    e.dvz = 1'b0;
    e.ovfl = 1'b0;
    if (bi == 0) begin
      e.q = (ai < 0) ? 16'h8000 : 16'h7FFF;
      e.r = a;
      e.dvz = 1'b1;
    end else if (ai == -32768 && bi == -1) begin
      e.q = 16'h7FFF;
      e.r = 16'h0000;
      e.ovfl = 1'b1;
    end else begin
      e.q = 16'(ai / bi);
      e.r = 16'(ai % bi);
    end
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 9))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("Q", {16'd0, Q}, {16'd0, e.q});
        check("R", {16'd0, R}, {16'd0, e.r});
        check("dvz", {31'd0, dvz}, {31'd0, e.dvz});
        check("ovfl", {31'd0, ovfl}, {31'd0, e.ovfl});
        check("latency", cyc - e.acc, 32'd18);
      end
    end
  end

  // Called just after a negedge while the DUT is idle; returns one negedge later.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    A = a;
    B = b;
    start = 1'b1;
    sb_q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int nd;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_Q", {16'd0, Q}, 32'd0);
    check("rst_R", {16'd0, R}, 32'd0);
    check("rst_dvz", {31'd0, dvz}, 32'd0);
    check("rst_ovfl", {31'd0, ovfl}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(16'd100, 16'd7);      wait_done();
    issue(16'hFF9C, 16'd7);     wait_done();
    issue(16'h8000, 16'hFFFF);  wait_done();
    issue(16'd5, 16'd0);        wait_done();
    issue(16'hFFFB, 16'd0);     wait_done();
    issue(16'h8000, 16'h0001);  wait_done();
    issue(16'h7FFF, 16'h8000);  wait_done();

    // Stray start mid-operation, then back-to-back start in the done cycle.
    issue(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    A = 16'd9;
    B = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    check("busy_mid", {31'd0, busy}, 32'd1);
    wait_done();
    issue(16'd9, 16'd3);
    wait_done();

    // Randomized operations with operand/start noise while busy.
    for (int n = 0; n < 200; n++) begin
      issue(rnd16(), rnd16());
      for (int k = 0; k < 10; k++) begin
        A = 16'($urandom);
        B = 16'($urandom);
        start = 1'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      wait_done();
      if ($urandom_range(0, 3) != 0)
        repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Abort by reset mid-operation.
    issue(16'd1000, 16'd3);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb_q.pop_back());
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_Q", {16'd0, Q}, 32'd0);
    check("abort_R", {16'd0, R}, 32'd0);
    check("abort_dvz", {31'd0, dvz}, 32'd0);
    check("abort_ovfl", {31'd0, ovfl}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 32'd0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);

    issue(16'hFC18, 16'd3);
    wait_done();

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdiv_16bit.md
SDIV_16BIT -- requirements
Module: sdiv_16bit

Interface
REQ-001 SHALL have parameter W, default 16, operand and result width; only 16 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a divide; sampled only in IDLE.
REQ-005 SHALL have port A  input  16  signed dividend, captured when start is accepted.
REQ-006 SHALL have port B  input  16  signed divisor, captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-008 SHALL have port done  output  1  single-cycle pulse; Q, R, dvz and ovfl are valid.
REQ-009 SHALL have port Q  output  16  signed quotient, held until the next done.
REQ-010 SHALL have port R  output  16  signed remainder, held until the next done.
REQ-011 SHALL have port dvz  output  1  divide-by-zero flag, held with Q.
REQ-012 SHALL have port ovfl  output  1  quotient-overflow flag, held with Q.

Function
REQ-013 SHALL implement states IDLE, PREP, ITER, FIN.
REQ-014 SHALL move IDLE->PREP on an edge where start=1, capturing A and B; start=0 SHALL keep IDLE.
REQ-015 In PREP, SHALL form absolute values of the captured operands, record both signs, clear the 4-bit iteration counter and move to ITER.
REQ-016 ITER SHALL run one restoring shift/subtract step per cycle for exactly 16 cycles, then move to FIN.
REQ-017 FIN SHALL register Q, R, dvz and ovfl, pulse done for one cycle, and return to IDLE.
REQ-018 Latency SHALL be fixed at 18 edges from acceptance to done high, for all operand values including zero and overflow cases.
REQ-019 Division SHALL truncate toward zero; R SHALL take the sign of A; |R| < |B|; A = Q*B + R.
REQ-020 If B=0: Q SHALL be 0x7FFF when A>=0 and 0x8000 when A<0; R SHALL equal A; dvz=1; ovfl=0.
REQ-021 If A=0x8000 and B=0xFFFF: Q SHALL be 0x7FFF (saturated); R=0; ovfl=1; dvz=0.
REQ-022 The magnitude of 0x8000 SHALL be handled as unsigned 0x8000 internally, using a 17-bit partial remainder.
REQ-023 start SHALL be ignored while busy=1; the in-flight result SHALL be unaffected.
REQ-024 A and B SHALL NOT be sampled after acceptance; changing them mid-operation SHALL have no effect.
REQ-025 start SHALL be accepted in the cycle done is high (back-to-back), because the state is IDLE then.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, done=0, Q=0, R=0, dvz=0, ovfl=0 and counter=0.
REQ-027 Reset during PREP/ITER/FIN SHALL abort the operation; no done SHALL follow the abort.

Structure
REQ-028 State encodings, W and the saturation constants 0x7FFF/0x8000 SHALL reside in a shared ALU package/header used by the ALU blocks.
REQ-029 The per-step subtract SHALL use one sub-module, addsub_17bit (combinational, sub input as carry-in); all other logic SHALL be in sdiv_16bit.

Verification
REQ-030 The bench SHALL check A=100, B=7 -> after 18 edges done=1, Q=0x000E, R=0x0002, dvz=0, ovfl=0.
REQ-031 The bench SHALL check A=-100 (0xFF9C), B=7 -> Q=0xFFF2, R=0xFFFE.
REQ-032 The bench SHALL check A=0x8000, B=0xFFFF -> Q=0x7FFF, R=0x0000, ovfl=1.
REQ-033 The bench SHALL check A=5, B=0 -> Q=0x7FFF, R=0x0005, dvz=1; and A=-5, B=0 -> Q=0x8000.
REQ-034 The bench SHALL start 100/7, drive start=1 with A=9, B=3 at edge 5, then start 9/3 in the done cycle -> first result 14 r2, no disturbance from edge 5; second result Q=3, R=0 at 18 edges after its acceptance.
REQ-035 The bench SHALL start 1000/3 and assert rst at edge 9 -> all outputs 0 immediately, state IDLE, no done pulse for the next 30 cycles.
